// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Front end for the 4-bit up/down counter. It synchronises the raw quadrature
//   channels, glitch-filters them, and decodes Gray-code transitions into a
//   one-cycle step pulse with a direction level (1 = up, 0 = down). It flags
//   illegal two-bit jumps with a one-cycle err pulse and never turns them into
//   a step.
//
//   Optional feature macro: QDEC_ERR_CNT_EN adds a saturating illegal-transition
//   counter (err_count, ERR_W bits wide).
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   enc_a      : raw encoder channel A (asynchronous)
//   enc_b      : raw encoder channel B (asynchronous)
//   step_valid : one-cycle pulse per legal transition
//   up_or_down : direction of the most recent legal step (1 = up)
//   err        : one-cycle pulse per illegal transition
//   ab_state   : filtered {A,B}
//   err_count  : saturating illegal-transition count (QDEC_ERR_CNT_EN only)

module quad_step_decoder #(
  parameter int FILT_CYCLES = 4
`ifdef QDEC_ERR_CNT_EN
  , parameter int ERR_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic             step_valid,
  output logic             up_or_down,
  output logic             err,
  output logic [1:0]       ab_state
`ifdef QDEC_ERR_CNT_EN
  , output logic [ERR_W-1:0] err_count
`endif
);

  typedef enum logic {INIT, TRACK} state_t;

  localparam logic [3:0] CNT_LAST    = 4'(FILT_CYCLES - 1);
  // INIT lasts 2+FILT_CYCLES cycles: settle counter runs 0 .. FILT_CYCLES+1.
  localparam logic [4:0] SETTLE_LAST = 5'(FILT_CYCLES + 1);

  state_t          state_q, state_d;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][3:0] filtCnt_q, filtCnt_d;
  logic [1:0]      prev_q, prev_d;
  logic [4:0]      settleCnt_q, settleCnt_d;
  logic            stepValid_q, stepValid_d;
  logic            err_q, err_d;
  logic            dir_q, dir_d;

  // Two-flop synchroniser per channel; bit 1 is A, bit 0 is B so the vector
  // reads as {A,B} everywhere downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {enc_a, enc_b};
      sync2_q <= sync1_q;
    end
  end

  // State register for the FSM, filters, previous-state tracker and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      filt_q      <= 2'b00;
      filtCnt_q   <= '0;
      prev_q      <= 2'b00;
      settleCnt_q <= '0;
      stepValid_q <= 1'b0;
      err_q       <= 1'b0;
      dir_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      filtCnt_q   <= filtCnt_d;
      prev_q      <= prev_d;
      settleCnt_q <= settleCnt_d;
      stepValid_q <= stepValid_d;
      err_q       <= err_d;
      dir_q       <= dir_d;
    end
  end

  // Next-state logic. INIT bypasses the filter so the filtered value and the
  // previous value both start equal to whatever the encoder rests at; this is
  // what keeps a non-00 rest position from looking like a transition. TRACK
  // runs the per-channel filters and decodes (prev, filt).
  always_comb begin
    state_d     = state_q;
    filt_d      = filt_q;
    filtCnt_d   = filtCnt_q;
    prev_d      = prev_q;
    settleCnt_d = settleCnt_q;
    stepValid_d = 1'b0;
    err_d       = 1'b0;
    dir_d       = dir_q;

    case (state_q)
      INIT: begin
        filt_d    = sync2_q;
        prev_d    = sync2_q;
        filtCnt_d = '0;
        if (settleCnt_q == SETTLE_LAST) begin
          state_d     = TRACK;
          settleCnt_d = '0;
        end else begin
          settleCnt_d = settleCnt_q + 5'd1;
        end
      end

      TRACK: begin
        for (int i = 0; i < 2; i++) begin
          if (sync2_q[i] != filt_q[i]) begin
            if (filtCnt_q[i] == CNT_LAST) begin
              filt_d[i]    = sync2_q[i];
              filtCnt_d[i] = '0;
            end else begin
              filtCnt_d[i] = filtCnt_q[i] + 4'd1;
            end
          end else begin
            filtCnt_d[i] = '0;
          end
        end

        prev_d = filt_q;

        // Up sequence is 00 -> 01 -> 11 -> 10 -> 00; a two-bit change is an
        // error that leaves the direction alone.
        case ({prev_q, filt_q})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
            stepValid_d = 1'b1;
            dir_d       = 1'b1;
          end
          4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
            stepValid_d = 1'b1;
            dir_d       = 1'b0;
          end
          4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
            err_d = 1'b1;
          end
          default: begin
          end
        endcase
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

`ifdef QDEC_ERR_CNT_EN
  logic [ERR_W-1:0] errCnt_q, errCnt_d;

  // Counts alongside the err pulse so both update on the same edge; holds at
  // all-ones once saturated.
  always_comb begin
    errCnt_d = errCnt_q;
    if (err_d && (errCnt_q != {ERR_W{1'b1}})) begin
      errCnt_d = errCnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      errCnt_q <= '0;
    end else begin
      errCnt_q <= errCnt_d;
    end
  end

  assign err_count = errCnt_q;
`endif

  assign step_valid = stepValid_q;
  assign err        = err_q;
  assign up_or_down = dir_q;
  assign ab_state   = filt_q;

endmodule
